// File: rtl/scan_wrap_pkg.sv
// Shared types for the scan wrapper chain: MODE encoding, FSM states and
// the decoded operation bundle used by the chain and its length checker.
package scan_wrap_pkg;

  typedef enum logic [1:0] {
    MODE_FUNC   = 2'd0,
    MODE_INTEST = 2'd1,
    MODE_EXTEST = 2'd2,
    MODE_SAFE   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADED   = 2'd1,
    ST_SHIFTING = 2'd2
  } state_e;

  // At most one of these is set in any cycle.
  typedef struct packed {
    logic cap;
    logic sft;
    logic upd;
  } op_t;

  // Gate the TAP qualifiers with the select and resolve
  // CAPTURE > SHIFT > UPDATE priority.
  function automatic op_t decode_op(input logic sel, input logic cap,
                                    input logic sft, input logic upd);
    op_t op;
    op.cap = sel & cap;
    op.sft = sel & sft & ~cap;
    op.upd = sel & upd & ~cap & ~sft;
    return op;
  endfunction

endpackage

// File: rtl/scan_wrap_len_chk.sv
// Saturating shift counter plus length compare for the scan wrapper chain.
// The counter clears on capture and saturates at WIDTH+1 so an overshift is
// still distinguishable from an exact-length shift.
module scan_wrap_len_chk
  import scan_wrap_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          len_bad
);

  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  logic [CW-1:0] cnt_d, cnt_q;

  // Next count: clear on capture, count shifts up to saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

  // A capture followed directly by update (zero shifts) is legal, as is an
  // exact WIDTH-shift load; anything else is a length mismatch.
  assign len_bad = (cnt_q != CNT_FULL) && (cnt_q != '0);

endmodule

// File: rtl/scan_wrap_chain.sv
// IEEE-1500 style wrapper boundary chain: capture/shift/update register
// pair with FUNC/INTEST/EXTEST/SAFE output muxing.
// Optional build macro: SCAN_WRAP_LEN_CHECK_EN -- when defined, an UPDATE
// after a wrong number of shifts raises LEN_ERR and is not committed.
// Handshake: there is no valid/ready; operations are single-cycle strobes
// qualified by TDR_SEL and resolved CAPTURE > SHIFT > UPDATE each cycle.
module scan_wrap_chain
  import scan_wrap_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] SAFE_VAL = {WIDTH{1'b0}},
  parameter int               CW       = $clog2(WIDTH + 2)
) (
  input  logic             TDR_TCK,
  input  logic             TDR_RESET,
  input  logic             TDR_SEL,
  input  logic             TDR_CAPTURE,
  input  logic             TDR_SHIFT,
  input  logic             TDR_UPDATE,
  input  logic [1:0]       MODE,
  input  logic             WSI,
  input  logic [WIDTH-1:0] CFI,
  output logic [WIDTH-1:0] CFO,
  output logic             WSO,
  output logic             LEN_ERR,
  output logic [CW-1:0]    SHIFT_CNT,
  output logic [1:0]       STATE_DBG
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] shift_d, shift_q;
  logic [WIDTH-1:0] upd_d, upd_q;
  logic [WIDTH-1:0] cfo;
  logic [WIDTH-1:0] cap_src;
  op_t              op;
  logic             upd_fire;
  logic             commit;
  logic             len_err_set;
  logic             len_bad;

  assign op = decode_op(TDR_SEL, TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE);

  scan_wrap_len_chk #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_len_chk (
    .clk     (TDR_TCK),
    .rst     (TDR_RESET),
    .clr     (op.cap),
    .inc     (op.sft),
    .cnt     (SHIFT_CNT),
    .len_bad (len_bad)
  );

  // FSM state register.
  always_ff @(posedge TDR_TCK) begin
    if (TDR_RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; an UPDATE with no capture since the last update is dropped.
  always_comb begin
    state_d = state_q;
    if (op.cap) begin
      state_d = ST_LOADED;
    end else if (op.sft) begin
      state_d = ST_SHIFTING;
    end else if (op.upd && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // FSM outputs: whether this UPDATE commits or flags a length error.
  always_comb begin
    upd_fire    = op.upd && (state_q != ST_IDLE);
`ifdef SCAN_WRAP_LEN_CHECK_EN
    commit      = upd_fire && !len_bad;
    len_err_set = upd_fire && len_bad;
`else
    commit      = upd_fire;
    len_err_set = 1'b0;
`endif
  end

  assign STATE_DBG = state_q;

  // Functional output mux; mode changes act in the same cycle.
  always_comb begin
    cfo = CFI;
    case (mode_e'(MODE))
      MODE_FUNC:   cfo = CFI;
      MODE_INTEST: cfo = upd_q;
      MODE_EXTEST: cfo = upd_q;
      MODE_SAFE:   cfo = SAFE_VAL;
      default:     cfo = CFI;
    endcase
  end

  assign CFO = cfo;

  // EXTEST captures what the wrapper is driving out; other modes capture CFI.
  assign cap_src = (mode_e'(MODE) == MODE_EXTEST) ? cfo : CFI;

  // Shift/update datapath next values; update_reg only moves on a commit.
  always_comb begin
    shift_d = shift_q;
    if (op.cap) begin
      shift_d = cap_src;
    end else if (op.sft) begin
      for (int i = 0; i < WIDTH - 1; i++) begin
        shift_d[i] = shift_q[i+1];
      end
      shift_d[WIDTH-1] = WSI;
    end
    upd_d = commit ? shift_q : upd_q;
  end

  // Datapath registers.
  always_ff @(posedge TDR_TCK) begin
    if (TDR_RESET) begin
      shift_q <= '0;
      upd_q   <= '0;
    end else begin
      shift_q <= shift_d;
      upd_q   <= upd_d;
    end
  end

  assign WSO = shift_q[0];

`ifdef SCAN_WRAP_LEN_CHECK_EN
  logic len_err_d, len_err_q;

  // Sticky length error: cleared by capture, set by a rejected update.
  always_comb begin
    len_err_d = len_err_q;
    if (op.cap) begin
      len_err_d = 1'b0;
    end else if (len_err_set) begin
      len_err_d = 1'b1;
    end
  end

  // Length error register.
  always_ff @(posedge TDR_TCK) begin
    if (TDR_RESET) begin
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= len_err_d;
    end
  end

  assign LEN_ERR = len_err_q;
`else
  logic unused_len;
  assign unused_len = len_bad | len_err_set;
  assign LEN_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_scan_wrap_chain.sv
// Directed bench for scan_wrap_chain (WIDTH=8, SAFE_VAL=8'hA5).
// The driver pushes expected values before each clock; a monitor pops and
// compares them on the following falling edge.
module tb_scan_wrap_chain;
  import scan_wrap_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 2);

  localparam int SIG_CFO   = 0;
  localparam int SIG_WSO   = 1;
  localparam int SIG_LEN   = 2;
  localparam int SIG_CNT   = 3;
  localparam int SIG_STATE = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic          cap = 1'b0;
  logic          sft = 1'b0;
  logic          upd = 1'b0;
  logic [1:0]    mode = 2'd3;
  logic          wsi = 1'b0;
  logic [W-1:0]  cfi = '0;
  logic [W-1:0]  cfo;
  logic          wso;
  logic          len_err;
  logic [CW-1:0] shift_cnt;
  logic [1:0]    state_dbg;

  scan_wrap_chain #(
    .WIDTH    (W),
    .SAFE_VAL (8'hA5)
  ) dut (
    .TDR_TCK     (clk),
    .TDR_RESET   (rst),
    .TDR_SEL     (sel),
    .TDR_CAPTURE (cap),
    .TDR_SHIFT   (sft),
    .TDR_UPDATE  (upd),
    .MODE        (mode),
    .WSI         (wsi),
    .CFI         (cfi),
    .CFO         (cfo),
    .WSO         (wso),
    .LEN_ERR     (len_err),
    .SHIFT_CNT   (shift_cnt),
    .STATE_DBG   (state_dbg)
  );

  // Scoreboard
  logic [15:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          checks   = 0;
  int          failures = 0;

  logic [15:0] mon_exp;
  logic [15:0] mon_act;
  int          mon_sel;
  string       mon_name;

  function automatic logic [15:0] actual_of(input int s);
    case (s)
      SIG_CFO:   return 16'(cfo);
      SIG_WSO:   return 16'(wso);
      SIG_LEN:   return 16'(len_err);
      SIG_CNT:   return 16'(shift_cnt);
      default:   return 16'(state_dbg);
    endcase
  endfunction

  task automatic expect_sig(input int s, input logic [15:0] e, input string n);
    sel_q.push_back(s);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // One clock edge; returns after the monitor has consumed the expectations.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare everything queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_sel  = sel_q.pop_front();
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = actual_of(mon_sel);
      checks++;
      if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h at %0t", mon_name, mon_act, mon_exp, $time);
      end
    end
  end

  // Hand tables for the 8'hC3 stream into a 8'h3C capture.
  logic [7:0] stream = 8'hC3;
  int         wso_after[1:8] = '{0, 1, 1, 1, 1, 0, 0, 1};
  logic [7:0] cfo_exp;

  // Driver
  initial begin
    // Reset with MODE=SAFE
    expect_sig(SIG_CFO, 16'hA5, "rst_cfo_safe");
    expect_sig(SIG_WSO, 16'h0, "rst_wso");
    expect_sig(SIG_LEN, 16'h0, "rst_len_err");
    expect_sig(SIG_CNT, 16'h0, "rst_cnt");
    expect_sig(SIG_STATE, 16'(ST_IDLE), "rst_state");
    step();
    rst  = 1'b0;
    mode = 2'd1;
    expect_sig(SIG_CFO, 16'h00, "rst_cfo_intest");
    step();

    // Full-length INTEST load of 8'hC3
    sel = 1'b1; cfi = 8'h3C; cap = 1'b1;
    expect_sig(SIG_STATE, 16'(ST_LOADED), "cap_state");
    expect_sig(SIG_WSO, 16'h0, "cap_wso");
    expect_sig(SIG_CNT, 16'h0, "cap_cnt");
    step();
    cap = 1'b0; sft = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wsi = stream[k-1];
      expect_sig(SIG_WSO, 16'(wso_after[k]), "shift_wso");
      expect_sig(SIG_CNT, 16'(k), "shift_cnt");
      expect_sig(SIG_CFO, 16'h00, "shift_cfo_hold");
      step();
    end
    sft = 1'b0; upd = 1'b1;
    expect_sig(SIG_CFO, 16'hC3, "upd_cfo");
    expect_sig(SIG_STATE, 16'(ST_IDLE), "upd_state");
    expect_sig(SIG_LEN, 16'h0, "upd_len_err");
    step();
    upd = 1'b0;

    // Short shift: 5 shifts then UPDATE
    cap = 1'b1;
    step();
    cap = 1'b0; sft = 1'b1; wsi = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    sft = 1'b0; upd = 1'b1;
`ifdef SCAN_WRAP_LEN_CHECK_EN
    expect_sig(SIG_LEN, 16'h1, "short_len_err");
    expect_sig(SIG_CFO, 16'hC3, "short_cfo_held");
`else
    expect_sig(SIG_LEN, 16'h0, "short_len_err");
    expect_sig(SIG_CFO, 16'h01, "short_cfo_commit");
`endif
    step();
    upd = 1'b0; cfi = 8'h5A; cap = 1'b1;
    expect_sig(SIG_LEN, 16'h0, "cap_clears_len_err");
    expect_sig(SIG_CNT, 16'h0, "cap_clears_cnt");
    step();
    cap = 1'b0; upd = 1'b1;
    expect_sig(SIG_CFO, 16'h5A, "cap_upd_commit");
    expect_sig(SIG_LEN, 16'h0, "cap_upd_len_err");
    step();

    // CAPTURE+UPDATE together, then 10 shifts (saturation)
    cfi = 8'h77; cap = 1'b1; upd = 1'b1;
    expect_sig(SIG_CFO, 16'h5A, "capupd_cfo_hold");
    expect_sig(SIG_STATE, 16'(ST_LOADED), "capupd_state");
    step();
    cap = 1'b0; upd = 1'b0; sft = 1'b1; wsi = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      upd = (k == 3);
      expect_sig(SIG_CNT, 16'((k > 9) ? 9 : k), "sat_cnt");
      expect_sig(SIG_CFO, 16'h5A, "sat_cfo_hold");
      step();
    end
    expect_sig(SIG_STATE, 16'(ST_SHIFTING), "sat_state");
    sft = 1'b0; upd = 1'b0;
    step();
    upd = 1'b1;
`ifdef SCAN_WRAP_LEN_CHECK_EN
    cfo_exp = 8'h5A;
    expect_sig(SIG_LEN, 16'h1, "over_len_err");
`else
    cfo_exp = 8'hFF;
    expect_sig(SIG_LEN, 16'h0, "over_len_err");
`endif
    expect_sig(SIG_CFO, 16'(cfo_exp), "over_cfo");
    step();
    upd = 1'b0;

    // Reset mid-shift with UPDATE asserted
    cfi = 8'h3C; cap = 1'b1;
    step();
    cap = 1'b0; sft = 1'b1; wsi = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    expect_sig(SIG_CNT, 16'h4, "pre_rst_cnt");
    sft = 1'b0;
    step();
    rst = 1'b1; upd = 1'b1;
    expect_sig(SIG_CNT, 16'h0, "midrst_cnt");
    expect_sig(SIG_WSO, 16'h0, "midrst_wso");
    expect_sig(SIG_LEN, 16'h0, "midrst_len_err");
    expect_sig(SIG_STATE, 16'(ST_IDLE), "midrst_state");
    expect_sig(SIG_CFO, 16'h00, "midrst_cfo");
    step();
    rst = 1'b0;
    expect_sig(SIG_CFO, 16'h00, "idle_upd_ignored");
    expect_sig(SIG_STATE, 16'(ST_IDLE), "idle_upd_state");
    step();
    upd = 1'b0;

    // EXTEST captures CFO; FUNC and SAFE muxing
    cfi = 8'h96; cap = 1'b1;
    step();
    cap = 1'b0; upd = 1'b1;
    expect_sig(SIG_CFO, 16'h96, "load_96");
    step();
    upd = 1'b0; mode = 2'd2; cfi = 8'h00;
    expect_sig(SIG_CFO, 16'h96, "extest_cfo");
    step();
    cap = 1'b1;
    expect_sig(SIG_WSO, 16'h0, "extest_cap_b0");
    step();
    cap = 1'b0; sft = 1'b1; wsi = 1'b0;
    expect_sig(SIG_WSO, 16'h1, "extest_cap_b1");
    step();
    expect_sig(SIG_WSO, 16'h1, "extest_cap_b2");
    step();
    expect_sig(SIG_WSO, 16'h0, "extest_cap_b3");
    step();
    sft = 1'b0; mode = 2'd0; cfi = 8'hE7;
    expect_sig(SIG_CFO, 16'hE7, "func_cfo");
    step();
    mode = 2'd3;
    expect_sig(SIG_CFO, 16'hA5, "safe_cfo");
    step();

    // Deselect for 3 cycles mid-shift
    mode = 2'd1; cfi = 8'h3C; cap = 1'b1;
    step();
    cap = 1'b0; sft = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wsi = stream[k-1];
      step();
    end
    sel = 1'b0; wsi = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_sig(SIG_CNT, 16'h4, "desel_cnt");
      expect_sig(SIG_WSO, 16'(wso_after[4]), "desel_wso");
      expect_sig(SIG_STATE, 16'(ST_SHIFTING), "desel_state");
      step();
    end
    sel = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      wsi = stream[k-1];
      expect_sig(SIG_WSO, 16'(wso_after[k]), "resume_wso");
      expect_sig(SIG_CNT, 16'(k), "resume_cnt");
      expect_sig(SIG_CFO, 16'h96, "resume_cfo_hold");
      step();
    end
    sft = 1'b0; upd = 1'b1;
    expect_sig(SIG_CFO, 16'hC3, "resume_upd_cfo");
    expect_sig(SIG_LEN, 16'h0, "resume_len_err");
    step();
    upd = 1'b0;
    step();

    // Every queued expectation must have been consumed.
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_wrap_chain.md
SCAN_WRAP_CHAIN -- requirements
Module: scan_wrap_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of wrapper cells in the chain (1..64).
REQ-002 SHALL have parameter SAFE_VAL, default {WIDTH{1'b0}}, WIDTH-bit value driven on CFO in SAFE mode.
REQ-003 SHALL have port TDR_TCK  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port TDR_RESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port TDR_SEL  input  1  chain selected; when low, CAPTURE/SHIFT/UPDATE are ignored.
REQ-006 SHALL have ports TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE  input  1 each  TAP-derived operation qualifiers.
REQ-007 SHALL have port MODE  input  2  0=FUNC, 1=INTEST, 2=EXTEST, 3=SAFE.
REQ-008 SHALL have port WSI  input  1  serial scan in.
REQ-009 SHALL have port CFI  input  WIDTH  functional data in.
REQ-010 SHALL have port CFO  output  WIDTH  functional data out.
REQ-011 SHALL have port WSO  output  1  serial scan out, shift_reg[0].
REQ-012 SHALL have port LEN_ERR  output  1  sticky shift-length mismatch flag.
REQ-013 SHALL have port SHIFT_CNT  output  $clog2(WIDTH+2)  shifts since last capture, saturating at WIDTH+1.

Function
REQ-014 Operations SHALL be gated by TDR_SEL; priority when several asserted: CAPTURE > SHIFT > UPDATE, lower ones ignored that cycle.
REQ-015 CAPTURE SHALL load shift_reg <= CFI (INTEST/FUNC/SAFE) or shift_reg <= CFO (EXTEST), clear SHIFT_CNT and LEN_ERR, next state LOADED.
REQ-016 SHIFT SHALL do shift_reg <= {WSI, shift_reg[WIDTH-1:1]}, increment SHIFT_CNT saturating at WIDTH+1, next state SHIFTING.
REQ-017 UPDATE SHALL copy shift_reg into update_reg one cycle later visible on CFO (1-cycle latency), next state IDLE.
REQ-018 FSM states SHALL be IDLE, LOADED, SHIFTING; UPDATE in IDLE (no capture since last update) SHALL be ignored.
REQ-019 CFO SHALL be combinational: FUNC -> CFI; INTEST/EXTEST -> update_reg; SAFE -> SAFE_VAL; MODE changes take effect same cycle.
REQ-020 update_reg SHALL hold its value during CAPTURE and SHIFT (no ripple on CFO).
REQ-021 WIDTH=1 SHALL work: shift_reg <= WSI on SHIFT.
REQ-022 TDR_SEL falling mid-SHIFTING SHALL freeze shift_reg, SHIFT_CNT, FSM state; resume on reassertion.

Reset
REQ-023 On TDR_RESET high at a rising edge: shift_reg=0, update_reg=0, WSO=0, SHIFT_CNT=0, LEN_ERR=0, state IDLE; CFO then per REQ-019 with update_reg=0.
REQ-024 Reset SHALL override all operations in the same cycle, including a simultaneous UPDATE.

Configuration
REQ-025 Macro SCAN_WRAP_LEN_CHECK_EN defined: UPDATE with SHIFT_CNT != WIDTH (and SHIFT_CNT != 0) SHALL set LEN_ERR and NOT write update_reg; SHIFT_CNT==0 (capture-update) commits.
REQ-026 Macro undefined: UPDATE SHALL always commit; LEN_ERR SHALL be tied 0; SHIFT_CNT still counts.

Structure
REQ-027 Package scan_wrap_pkg SHALL hold the MODE encoding typedef/constants and FSM state typedef.
REQ-028 One sub-module scan_wrap_len_chk SHALL contain the saturating SHIFT_CNT counter and length compare.

Verification (WIDTH=8, SAFE_VAL=8'hA5)
REQ-029 Reset, MODE=SAFE -> CFO=8'hA5, WSO=0, LEN_ERR=0; MODE=INTEST -> CFO=8'h00.
REQ-030 MODE=INTEST, CFI=8'h3C, CAPTURE, 8 SHIFTs with WSI stream of 8'hC3 LSB first, UPDATE -> WSO outputs 0,0,1,1,1,1,0,0; CFO=8'hC3 one cycle after UPDATE.
REQ-031 With SCAN_WRAP_LEN_CHECK_EN: CAPTURE, 5 SHIFTs, UPDATE -> LEN_ERR=1, CFO unchanged; next CAPTURE clears LEN_ERR; without macro CFO updates, LEN_ERR=0.
REQ-032 CAPTURE and UPDATE asserted same cycle -> capture only, CFO unchanged; 10 SHIFTs -> SHIFT_CNT=9 (saturated).
REQ-033 TDR_RESET asserted after 4 of 8 SHIFTs -> all state zero next cycle, subsequent UPDATE ignored (IDLE).
REQ-034 TDR_SEL low for 3 cycles mid-shift with TDR_SHIFT high -> SHIFT_CNT and WSO frozen; total 8 selected shifts then UPDATE commits cleanly.
